// File: rtl/mem_arbiter_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : mem_arbiter_pkg
// Description : Shared definitions for the memory-port arbiter: FSM state
//               encodings, grant owner codes and default bus widths.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_arbiter_pkg;

    // Default bus widths
    localparam int c_ADDR_W_DEF = 32;
    localparam int c_DATA_W_DEF = 32;

    // Arbiter FSM state encoding
    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_ISSUE = 2'd1;
    localparam logic [1:0] c_ST_WAIT  = 2'd2;

    // Transaction owner codes (value of the grant output)
    localparam logic c_GRANT_IFU = 1'b0;
    localparam logic c_GRANT_LSU = 1'b1;

endpackage : mem_arbiter_pkg
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : mem_arbiter
// Description : Shares one memory port between instruction fetch (m0,
//               read-only) and load/store (m1, read/write). One transaction
//               is outstanding at a time; the winning request is registered
//               before it is issued downstream, and the response is routed
//               combinationally back to the owner.
//
// Ports       : clk, rst          - clock, synchronous active-high reset
//               m0_*              - fetch request/response channel
//               m1_*              - load/store request/response channel
//               s_*               - downstream memory request/response
//               grant             - owner of current transaction (0=m0,1=m1)
//
// Build macro : MEM_ARBITER_RR_EN - when defined, contention is resolved
//               round-robin (requester not granted last wins); otherwise m1
//               always wins over m0.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = c_ADDR_W_DEF,
    parameter int DATA_W = c_DATA_W_DEF
) (
    input  logic                clk,
    input  logic                rst,

    input  logic                m0_req_valid,
    output logic                m0_req_ready,
    input  logic [ADDR_W-1:0]   m0_addr,
    output logic                m0_resp_valid,
    input  logic                m0_resp_ready,
    output logic [DATA_W-1:0]   m0_rdata,

    input  logic                m1_req_valid,
    output logic                m1_req_ready,
    input  logic [ADDR_W-1:0]   m1_addr,
    input  logic                m1_wen,
    input  logic [DATA_W-1:0]   m1_wdata,
    input  logic [DATA_W/8-1:0] m1_wmask,
    output logic                m1_resp_valid,
    input  logic                m1_resp_ready,
    output logic [DATA_W-1:0]   m1_rdata,

    output logic                s_req_valid,
    input  logic                s_req_ready,
    output logic [ADDR_W-1:0]   s_addr,
    output logic                s_wen,
    output logic [DATA_W-1:0]   s_wdata,
    output logic [DATA_W/8-1:0] s_wmask,
    input  logic                s_resp_valid,
    output logic                s_resp_ready,
    input  logic [DATA_W-1:0]   s_rdata,

    output logic                grant
);

    logic [1:0]          r_state;
    logic [1:0]          w_state_nxt;
    logic                r_grant;
    logic [ADDR_W-1:0]   r_addr;
    logic                r_wen;
    logic [DATA_W-1:0]   r_wdata;
    logic [DATA_W/8-1:0] r_wmask;

    logic                w_pick;        // requester that would win this cycle
    logic                w_accept;      // request handshake with either master
    logic                w_owner_ready; // response ready of the current owner

    // ------------------------------------------------------------------------
    // Winner selection
    // ------------------------------------------------------------------------
`ifdef MEM_ARBITER_RR_EN
    logic r_last_grant;

    // On contention the requester that was not served last wins; a lone
    // requester always wins.
    always_comb begin
        if (m0_req_valid && m1_req_valid) begin
            w_pick = ~r_last_grant;
        end else begin
            w_pick = m1_req_valid ? c_GRANT_LSU : c_GRANT_IFU;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_grant <= c_GRANT_IFU;
        end else if (w_accept) begin
            r_last_grant <= w_pick;
        end
    end
`else
    // Fixed priority: load/store beats fetch.
    always_comb begin
        w_pick = m1_req_valid ? c_GRANT_LSU : c_GRANT_IFU;
    end
`endif

    assign w_owner_ready = (r_grant == c_GRANT_LSU) ? m1_resp_ready : m0_resp_ready;
    assign w_accept      = m0_req_ready || m1_req_ready;

    // ------------------------------------------------------------------------
    // FSM next state and handshake outputs
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt   = r_state;
        m0_req_ready  = 1'b0;
        m1_req_ready  = 1'b0;
        s_req_valid   = 1'b0;
        s_resp_ready  = 1'b0;
        m0_resp_valid = 1'b0;
        m1_resp_valid = 1'b0;

        case (r_state)
            c_ST_IDLE: begin
                m1_req_ready = m1_req_valid && (w_pick == c_GRANT_LSU);
                m0_req_ready = m0_req_valid && (w_pick == c_GRANT_IFU);
                if (m0_req_valid || m1_req_valid) begin
                    w_state_nxt = c_ST_ISSUE;
                end
            end
            c_ST_ISSUE: begin
                s_req_valid = 1'b1;
                if (s_req_ready) begin
                    w_state_nxt = c_ST_WAIT;
                end
            end
            c_ST_WAIT: begin
                s_resp_ready  = w_owner_ready;
                m0_resp_valid = s_resp_valid && (r_grant == c_GRANT_IFU);
                m1_resp_valid = s_resp_valid && (r_grant == c_GRANT_LSU);
                if (s_resp_valid && w_owner_ready) begin
                    w_state_nxt = c_ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase

        // Reset wins over everything: no handshake may complete in the reset
        // cycle, so an in-flight transaction is dropped cleanly.
        if (rst) begin
            w_state_nxt   = c_ST_IDLE;
            m0_req_ready  = 1'b0;
            m1_req_ready  = 1'b0;
            s_req_valid   = 1'b0;
            s_resp_ready  = 1'b0;
            m0_resp_valid = 1'b0;
            m1_resp_valid = 1'b0;
        end
    end

    // ------------------------------------------------------------------------
    // State register and request capture
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
            r_grant <= c_GRANT_IFU;
            r_addr  <= '0;
            r_wen   <= 1'b0;
            r_wdata <= '0;
            r_wmask <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_grant <= w_pick;
                if (w_pick == c_GRANT_LSU) begin
                    r_addr  <= m1_addr;
                    r_wen   <= m1_wen;
                    r_wdata <= m1_wdata;
                    r_wmask <= m1_wmask;
                end else begin
                    // Fetch is read-only: write fields forced inactive.
                    r_addr  <= m0_addr;
                    r_wen   <= 1'b0;
                    r_wdata <= '0;
                    r_wmask <= '0;
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Downstream request fields and response data
    // ------------------------------------------------------------------------
    assign s_addr   = r_addr;
    assign s_wen    = r_wen;
    assign s_wdata  = r_wdata;
    assign s_wmask  = r_wmask;
    assign grant    = r_grant;

    // Read data is only meaningful alongside the owner's resp_valid.
    assign m0_rdata = s_rdata;
    assign m1_rdata = s_rdata;

endmodule : mem_arbiter
`default_nettype wire
